// File: rtl/csr_access_ctrl.sv
// ---------------------------------------------------------------------------
// csr_access_ctrl
//
// Sequences one CSR instruction at a time through the CSR register file and
// the combinational CSR execute datapath: read -> execute -> write-back ->
// response. The old CSR value is returned for rd. The shared register-file
// write port is arbitrated between instruction write-back and single-cycle
// trap-unit writes; a trap is only granted while the controller is idle, so
// an instruction in flight is never split by a trap write.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   req_*                    instruction request from execute stage (valid/ready)
//   flush_i                  pipeline flush
//   resp_*                   response to consumer (valid/ready), old value + error
//   csr_raddr_o/csr_rdata_i  register-file read port (data one cycle later)
//   csr_wen_o/waddr/wdata    register-file write port
//   exe_*_o / exe_data*_i    operands to and result from the execute datapath
//   trap_*                   trap-unit write request and grant
// ---------------------------------------------------------------------------
module csr_access_ctrl #(
    parameter int XLEN      = 64,
    parameter int IMM_LEN   = 64,
    parameter int CSROP_LEN = 3,
    parameter int CSR_AW    = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [CSR_AW-1:0]    req_addr_i,
    input  logic [CSROP_LEN-1:0] req_op_i,
    input  logic [XLEN-1:0]      req_rs1_i,
    input  logic [IMM_LEN-1:0]   req_imm_i,
    input  logic                 req_imm_valid_i,
    input  logic                 flush_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [XLEN-1:0]      resp_rdata_o,
    output logic                 resp_err_o,
    output logic [CSR_AW-1:0]    csr_raddr_o,
    input  logic [XLEN-1:0]      csr_rdata_i,
    output logic                 csr_wen_o,
    output logic [CSR_AW-1:0]    csr_waddr_o,
    output logic [XLEN-1:0]      csr_wdata_o,
    output logic [XLEN-1:0]      exe_csr_data_o,
    output logic [XLEN-1:0]      exe_rs1_o,
    output logic [IMM_LEN-1:0]   exe_imm_o,
    output logic                 exe_imm_valid_o,
    output logic [CSROP_LEN-1:0] exe_op_o,
    input  logic [XLEN-1:0]      exe_data_i,
    input  logic                 exe_data_valid_i,
    input  logic                 trap_req_i,
    input  logic [CSR_AW-1:0]    trap_addr_i,
    input  logic [XLEN-1:0]      trap_wdata_i,
    output logic                 trap_gnt_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]           state_q,     state_d;
    logic [CSR_AW-1:0]    addr_q,      addr_d;
    logic [CSROP_LEN-1:0] op_q,        op_d;
    logic [XLEN-1:0]      rs1_q,       rs1_d;
    logic [IMM_LEN-1:0]   imm_q,       imm_d;
    logic                 imm_valid_q, imm_valid_d;
    logic [XLEN-1:0]      old_q,       old_d;
    logic                 err_q,       err_d;

    logic in_idle_s;
    logic accept_s;
    logic illegal_s;
    logic wb_wen_s;

    // Handshake, arbitration and write-back qualifiers. Idle is gated with
    // rst so ready/grant drop immediately while reset is held.
    always_comb begin
        in_idle_s   = (rst == 1'b1) && (state_q == S_IDLE);
        trap_gnt_o  = in_idle_s & trap_req_i;
        req_ready_o = in_idle_s & ~trap_req_i & ~flush_i;
        accept_s    = req_valid_i & req_ready_o;
        // Address bits [11:10] == 2'b11 mark a read-only CSR.
        illegal_s   = (state_q == S_WB) && (addr_q[CSR_AW-1 -: 2] == 2'b11) && exe_data_valid_i;
        wb_wen_s    = (state_q == S_WB) && exe_data_valid_i && !illegal_s;
    end

    // Next-state and operand latch logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        op_d        = op_q;
        rs1_d       = rs1_q;
        imm_d       = imm_q;
        imm_valid_d = imm_valid_q;
        old_d       = old_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    addr_d      = req_addr_i;
                    op_d        = req_op_i;
                    rs1_d       = req_rs1_i;
                    imm_d       = req_imm_i;
                    imm_valid_d = req_imm_valid_i;
                    state_d     = S_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                // Register-file data for the address issued in RD arrives now.
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    old_d   = csr_rdata_i;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                // Flush is ignored here: the write commits with the instruction.
                err_d   = illegal_s;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (flush_i || resp_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latch registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            op_q        <= '0;
            rs1_q       <= '0;
            imm_q       <= '0;
            imm_valid_q <= 1'b0;
            old_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            rs1_q       <= rs1_d;
            imm_q       <= imm_d;
            imm_valid_q <= imm_valid_d;
            old_q       <= old_d;
            err_q       <= err_d;
        end
    end

    // Write-port mux (trap wins; it can only be granted in idle) and outputs.
    always_comb begin
        csr_wen_o = trap_gnt_o | wb_wen_s;
        if (trap_gnt_o) begin
            csr_waddr_o = trap_addr_i;
            csr_wdata_o = trap_wdata_i;
        end else if (wb_wen_s) begin
            csr_waddr_o = addr_q;
            csr_wdata_o = exe_data_i;
        end else begin
            csr_waddr_o = '0;
            csr_wdata_o = '0;
        end
        resp_valid_o = (state_q == S_RESP);
        if (resp_valid_o) begin
            resp_rdata_o = old_q;
            resp_err_o   = err_q;
        end else begin
            resp_rdata_o = '0;
            resp_err_o   = 1'b0;
        end
        csr_raddr_o     = addr_q;
        exe_csr_data_o  = old_q;
        exe_rs1_o       = rs1_q;
        exe_imm_o       = imm_q;
        exe_imm_valid_o = imm_valid_q;
        exe_op_o        = op_q;
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [11:0] req_addr_i = '0;
    logic [2:0]  req_op_i = '0;
    logic [63:0] req_rs1_i = '0;
    logic [63:0] req_imm_i = '0;
    logic        req_imm_valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [63:0] resp_rdata_o;
    logic        resp_err_o;
    logic [11:0] csr_raddr_o;
    logic [63:0] csr_rdata_i;
    logic        csr_wen_o;
    logic [11:0] csr_waddr_o;
    logic [63:0] csr_wdata_o;
    logic [63:0] exe_csr_data_o, exe_rs1_o, exe_imm_o;
    logic        exe_imm_valid_o;
    logic [2:0]  exe_op_o;
    logic [63:0] exe_data_i;
    logic        exe_data_valid_i;
    logic        trap_req_i = 1'b0;
    logic [11:0] trap_addr_i = '0;
    logic [63:0] trap_wdata_i = '0;
    logic        trap_gnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    int wen_cnt = 0;
    int exp_wen = 0;

    logic [63:0] rf_mem  [0:4095];   // register file driven by the DUT
    logic [63:0] ref_mem [0:4095];   // reference contents kept by the model
    logic [11:0] pool    [0:7];

    localparam logic [11:0] TRAP_A = 12'h343;

    csr_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_op_i(req_op_i), .req_rs1_i(req_rs1_i),
        .req_imm_i(req_imm_i), .req_imm_valid_i(req_imm_valid_i),
        .flush_i(flush_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i),
        .csr_wen_o(csr_wen_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .exe_csr_data_o(exe_csr_data_o), .exe_rs1_o(exe_rs1_o), .exe_imm_o(exe_imm_o),
        .exe_imm_valid_o(exe_imm_valid_o), .exe_op_o(exe_op_o),
        .exe_data_i(exe_data_i), .exe_data_valid_i(exe_data_valid_i),
        .trap_req_i(trap_req_i), .trap_addr_i(trap_addr_i), .trap_wdata_i(trap_wdata_i),
        .trap_gnt_o(trap_gnt_o)
    );

    always #5 clk = ~clk;

    // Register file: one-cycle read latency, write on enable.
    always @(posedge clk) begin
        if (csr_wen_o) rf_mem[csr_waddr_o] <= csr_wdata_o;
        csr_rdata_i <= rf_mem[csr_raddr_o];
    end

    // Count every write-port pulse.
    always @(posedge clk) begin
        if (csr_wen_o) wen_cnt <= wen_cnt + 1;
    end

    // Execute datapath: 1=rw, 2=rs, 3=rc, others no write.
    logic [63:0] opnd_s;
    always_comb begin
        opnd_s = exe_imm_valid_o ? exe_imm_o : exe_rs1_o;
        exe_data_i = '0;
        exe_data_valid_i = 1'b0;
        case (exe_op_o)
            3'd1: begin exe_data_i = opnd_s; exe_data_valid_i = 1'b1; end
            3'd2: begin exe_data_i = exe_csr_data_o | opnd_s; exe_data_valid_i = (opnd_s != 64'd0); end
            3'd3: begin exe_data_i = exe_csr_data_o & ~opnd_s; exe_data_valid_i = (opnd_s != 64'd0); end
            default: begin exe_data_i = '0; exe_data_valid_i = 1'b0; end
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // Expected instruction outcome from the ISA rules.
    task automatic predict(input logic [11:0] a, input logic [2:0] op, input logic [63:0] rs1,
                           input logic [63:0] imm, input logic immv,
                           output logic [63:0] old, output logic [63:0] nv,
                           output logic wr, output logic err);
        logic [63:0] o;
        logic wv, ro;
        old = ref_mem[a];
        o = immv ? imm : rs1;
        nv = '0; wv = 1'b0;
        if (op == 3'd1) begin nv = o; wv = 1'b1; end
        else if (op == 3'd2) begin nv = old | o; wv = (o != 0); end
        else if (op == 3'd3) begin nv = old & ~o; wv = (o != 0); end
        ro  = (a[11:10] == 2'b11);
        wr  = wv & ~ro;
        err = wv & ro;
    endtask

    task automatic trap_write(input logic [11:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        trap_req_i = 1'b1; trap_addr_i = a; trap_wdata_i = d;
        #1;
        check_eq("trap_gnt", trap_gnt_o, 1'b1);
        check_eq("trap_waddr", csr_waddr_o, a);
        check_eq("trap_wdata", csr_wdata_o, d);
        @(posedge clk);
        ref_mem[a] = d; exp_wen++;
        #1 trap_req_i = 1'b0;
    endtask

    task automatic present(input logic [11:0] a, input logic [2:0] op, input logic [63:0] rs1,
                           input logic [63:0] imm, input logic immv);
        req_valid_i = 1'b1; req_addr_i = a; req_op_i = op;
        req_rs1_i = rs1; req_imm_i = imm; req_imm_valid_i = immv;
    endtask

    // Accept edge then scramble the request bus so stale inputs cannot leak.
    task automatic accept_edge();
        #1 check_eq("req_ready", req_ready_o, 1'b1);
        @(posedge clk); #1;
        req_valid_i = 1'b0; req_addr_i = 12'($urandom); req_rs1_i = {$urandom, $urandom};
        req_op_i = 3'($urandom); req_imm_i = {$urandom, $urandom};
    endtask

    task automatic run_instr(input logic [11:0] a, input logic [2:0] op, input logic [63:0] rs1,
                             input logic [63:0] imm, input logic immv, input int stall,
                             input logic trap_first, input logic trap_in_wb);
        logic [63:0] old, nv, td;
        logic wr, err;
        @(posedge clk); #1;
        present(a, op, rs1, imm, immv);
        if (trap_first) begin
            td = {$urandom, $urandom};
            trap_req_i = 1'b1; trap_addr_i = TRAP_A; trap_wdata_i = td;
            #1;
            check_eq("tf_ready", req_ready_o, 1'b0);
            check_eq("tf_gnt", trap_gnt_o, 1'b1);
            check_eq("tf_wen", csr_wen_o, 1'b1);
            check_eq("tf_wdata", csr_wdata_o, td);
            @(posedge clk);
            ref_mem[TRAP_A] = td; exp_wen++;
            #1 trap_req_i = 1'b0;
        end
        predict(a, op, rs1, imm, immv, old, nv, wr, err);
        accept_edge();
        check_eq("rd_raddr", csr_raddr_o, a);
        check_eq("rd_valid", resp_valid_o, 1'b0);
        @(posedge clk); #1;
        check_eq("ex_wen", csr_wen_o, 1'b0);
        @(posedge clk); #1;
        if (trap_in_wb) begin
            td = {$urandom, $urandom};
            trap_req_i = 1'b1; trap_addr_i = TRAP_A; trap_wdata_i = td;
        end
        #1;
        check_eq("wb_wen", csr_wen_o, wr);
        check_eq("wb_trap_gnt", trap_gnt_o, 1'b0);
        check_eq("wb_exe_old", exe_csr_data_o, old);
        if (wr) begin
            check_eq("wb_waddr", csr_waddr_o, a);
            check_eq("wb_wdata", csr_wdata_o, nv);
        end
        @(posedge clk);
        if (wr) begin ref_mem[a] = nv; exp_wen++; end
        #1;
        check_eq("resp_valid", resp_valid_o, 1'b1);
        check_eq("resp_rdata", resp_rdata_o, old);
        check_eq("resp_err", resp_err_o, err);
        check_eq("resp_ready_blk", req_ready_o, 1'b0);
        check_eq("resp_trap_gnt", trap_gnt_o, 1'b0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_eq("stall_valid", resp_valid_o, 1'b1);
            check_eq("stall_rdata", resp_rdata_o, old);
            check_eq("stall_ready", req_ready_o, 1'b0);
        end
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        #1;
        check_eq("post_valid", resp_valid_o, 1'b0);
        if (trap_in_wb) begin
            check_eq("late_trap_gnt", trap_gnt_o, 1'b1);
            check_eq("late_trap_wdata", csr_wdata_o, td);
            @(posedge clk);
            ref_mem[TRAP_A] = td; exp_wen++;
            #1 trap_req_i = 1'b0;
        end else begin
            check_eq("post_ready", req_ready_o, 1'b1);
        end
        check_eq("wen_count", wen_cnt, exp_wen);
    endtask

    // where: 1 = RD, 2 = EX, 3 = RESP
    task automatic flush_instr(input logic [11:0] a, input logic [63:0] rs1, input int where);
        logic [63:0] old, nv;
        logic wr, err;
        @(posedge clk); #1;
        present(a, 3'd1, rs1, 64'd0, 1'b0);
        predict(a, 3'd1, rs1, 64'd0, 1'b0, old, nv, wr, err);
        accept_edge();
        if (where >= 2) begin @(posedge clk); #1; end
        if (where == 3) begin
            @(posedge clk);
            @(posedge clk);
            if (wr) begin ref_mem[a] = nv; exp_wen++; end
            #1 check_eq("fl_resp_valid", resp_valid_o, 1'b1);
        end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        #1;
        check_eq("fl_resp_valid_after", resp_valid_o, 1'b0);
        check_eq("fl_idle_ready", req_ready_o, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check_eq("fl_resp_never", resp_valid_o, 1'b0);
        check_eq("fl_wen_count", wen_cnt, exp_wen);
    endtask

    initial begin
        logic [11:0] a;
        logic [63:0] r;
        pool[0] = 12'h340; pool[1] = 12'h300; pool[2] = 12'h305; pool[3] = 12'h341;
        pool[4] = 12'hF14; pool[5] = 12'hC00; pool[6] = 12'h7C0; pool[7] = 12'h342;

        // Reset state, with a trap request pending to show grant is held off.
        trap_req_i = 1'b1;
        #12;
        check_eq("rst_ready", req_ready_o, 1'b0);
        check_eq("rst_gnt", trap_gnt_o, 1'b0);
        check_eq("rst_wen", csr_wen_o, 1'b0);
        check_eq("rst_valid", resp_valid_o, 1'b0);
        check_eq("rst_rdata", resp_rdata_o, 64'd0);
        trap_req_i = 1'b0;
        @(negedge clk) rst = 1'b1;

        // Preload CSRs through the trap port.
        trap_write(12'h340, 64'h1234);
        trap_write(12'h300, 64'h8);
        trap_write(12'hF14, 64'h5);
        for (int i = 2; i < 8; i++) begin
            if (pool[i] != 12'hF14) trap_write(pool[i], {$urandom, $urandom});
        end

        run_instr(12'h340, 3'd1, 64'hDEAD, 64'd0, 1'b0, 0, 1'b0, 1'b0);   // csrrw
        run_instr(12'h300, 3'd2, 64'd0,    64'd0, 1'b0, 0, 1'b0, 1'b0);   // csrrs x0
        run_instr(12'hF14, 3'd1, 64'h77,   64'd0, 1'b0, 0, 1'b0, 1'b0);   // rw to read-only
        run_instr(12'h305, 3'd3, 64'hF0,   64'd0, 1'b0, 0, 1'b1, 1'b0);   // trap collides
        run_instr(12'h341, 3'd2, 64'd0,    64'd9, 1'b1, 3, 1'b0, 1'b1);   // stall, trap in WB

        flush_instr(12'h342, 64'h11, 1);
        flush_instr(12'h342, 64'h22, 2);
        flush_instr(12'h342, 64'h33, 3);

        // Flush in idle blocks acceptance.
        @(posedge clk); #1;
        present(12'h340, 3'd1, 64'h99, 64'd0, 1'b0);
        flush_i = 1'b1;
        #1 check_eq("idle_flush_ready", req_ready_o, 1'b0);
        @(posedge clk); #1;
        flush_i = 1'b0; req_valid_i = 1'b0;
        #1 check_eq("idle_flush_not_taken", req_ready_o, 1'b1);

        // Reset asserted during write-back.
        @(posedge clk); #1;
        present(12'h340, 3'd1, 64'hBAD, 64'd0, 1'b0);
        accept_edge();
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_wen", csr_wen_o, 1'b0);
        check_eq("mid_rst_ready", req_ready_o, 1'b0);
        check_eq("mid_rst_valid", resp_valid_o, 1'b0);
        check_eq("mid_rst_raddr", csr_raddr_o, 12'd0);
        check_eq("mid_rst_exe", exe_csr_data_o, 64'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_ready", req_ready_o, 1'b1);
        check_eq("post_rst_wen_count", wen_cnt, exp_wen);

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            a = pool[$urandom_range(0, 7)];
            r = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            run_instr(a, 3'($urandom_range(0, 4)), r, 64'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Sequencer in front of the CSR register file and the combinational CSR execute datapath.
- Accepts one CSR instruction at a time from the execute stage via valid/ready handshake.
- Runs read → execute → write-back → response; returns the old CSR value for rd.
- Arbitrates the shared CSR write port between instruction write-back and single-cycle trap-unit writes; trap has priority, granted only when idle.

Parameters:
- XLEN, `XLEN (64), data width.
- IMM_LEN, `IMM_LEN (64), zimm operand width.
- CSROP_LEN, `CSROP_LEN, CSR op-code width.
- CSR_AW, 12, CSR address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid_i  in  1  CSR instruction request
- req_ready_o  out  1  controller can accept
- req_addr_i  in  CSR_AW  CSR address
- req_op_i  in  CSROP_LEN  `CSROP_* code
- req_rs1_i  in  XLEN  rs1 data
- req_imm_i  in  IMM_LEN  zimm
- req_imm_valid_i  in  1  immediate form
- flush_i  in  1  pipeline flush
- resp_valid_o  out  1  result ready
- resp_ready_i  in  1  consumer accepts
- resp_rdata_o  out  XLEN  old CSR value (rd)
- resp_err_o  out  1  illegal write to read-only CSR
- csr_raddr_o  out  CSR_AW  regfile read address; data returns 1 cycle later
- csr_rdata_i  in  XLEN  regfile read data
- csr_wen_o  out  1  regfile write enable
- csr_waddr_o  out  CSR_AW  write address
- csr_wdata_o  out  XLEN  write data
- exe_csr_data_o, exe_rs1_o, exe_imm_o, exe_imm_valid_o, exe_op_o  out  XLEN/XLEN/IMM_LEN/1/CSROP_LEN  operands to execute datapath
- exe_data_i  in  XLEN  execute result
- exe_data_valid_i  in  1  execute result must be written
- trap_req_i  in  1  trap unit write request
- trap_addr_i  in  CSR_AW  trap write address
- trap_wdata_i  in  XLEN  trap write data
- trap_gnt_o  out  1  trap write performed this cycle

Behaviour:
- Reset (rst=0, async): state IDLE; all request/operand latches 0; req_ready_o=0, resp_valid_o=0, resp_err_o=0, csr_wen_o=0, trap_gnt_o=0, all data outputs 0.
- FSM states: IDLE, RD, EX, WB, RESP; one state per cycle except RESP.
- IDLE:
  - trap_gnt_o = trap_req_i; on grant, csr_wen_o=1, waddr/wdata from trap port.
  - req_ready_o = ~trap_req_i.
  - On req_valid_i & req_ready_o: latch addr/op/rs1/imm/imm_valid; go to RD.
- RD: csr_raddr_o = latched addr (driven from latch in all states); go to EX.
- EX: capture csr_rdata_i into old_q; go to WB.
- WB:
  - exe_* outputs driven from old_q and latches.
  - illegal = (addr[11:10]==2'b11) & exe_data_valid_i.
  - csr_wen_o = exe_data_valid_i & ~illegal, exactly one cycle; waddr = latched addr, wdata = exe_data_i.
  - err_q ← illegal; go to RESP.
- RESP:
  - resp_valid_o=1, resp_rdata_o=old_q, resp_err_o=err_q; outputs held stable until resp_ready_i.
  - On handshake, return to IDLE.
  - No new request is accepted in the same cycle.
- Latency: accept at cycle N → wen at N+3 → resp_valid_o first high at N+4. Throughput: one instruction per 5 cycles minimum.
- CSROP_READ/NONE: exe_data_valid_i=0, so no write; response still returned with old value.
- flush_i:
  - in RD/EX → IDLE next cycle; no write, no response.
  - in WB: ignored; write commits.
  - in RESP: response dropped → IDLE.
  - in IDLE: blocks acceptance that cycle.
- trap_gnt_o is 0 outside IDLE; trap requests wait until IDLE (instruction atomicity).
- Mid-operation reset: immediate IDLE, no pending write or response survives.

Test Plan:
- csrrw addr 0x340, rs1=0xDEAD, regfile holds 0x1234 → wen at N+3 with wdata 0xDEAD; resp_rdata_o=0x1234 at N+4; resp_err_o=0.
- csrrs rs1=0 (exe_data_valid_i=0) on 0x300=0x8 → csr_wen_o never high; resp_rdata_o=0x8.
- csrrw to 0xF14 (read-only) → no wen; resp_err_o=1; resp_rdata_o = old mhartid value.
- trap_req_i and req_valid_i together in IDLE → trap_gnt_o=1, wen with trap data, req_ready_o=0. Next cycle trap low → request accepted. trap_req_i raised during WB → no grant until IDLE.
- flush_i in EX → no wen, no resp_valid, IDLE next cycle. Separately, resp_ready_i held 0 for 3 cycles in RESP → resp_rdata_o stable, req_ready_o=0 throughout.
- rst asserted in WB → csr_wen_o and all outputs 0 asynchronously; after release, req_ready_o=1 in IDLE.
